// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared types and IEEE-754 single-precision constants for the
//            CORDIC accelerator datapath (fixed-to-float return path).
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;

    typedef enum logic [2:0] {
        F2F_IDLE = 3'd0,
        F2F_ABS  = 3'd1,
        F2F_NORM = 3'd2,
        F2F_PACK = 3'd3,
        F2F_DONE = 3'd4
    } f2f_state_t;

    function automatic logic [31:0] fp_pack(
        input logic                 sign,
        input logic [FP_EXP_W-1:0]  exponent,
        input logic [FP_MANT_W-1:0] mantissa
    );
        return {sign, exponent, mantissa};
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder32.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder32
// Brief    : Index of the most significant set bit of a 32-bit word;
//            o_valid low means the word is zero.
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder32 (
    input  logic [31:0] i_data,
    output logic [4:0]  o_index,
    output logic        o_valid
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        o_index = 5'd0;
        o_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) begin
                o_index = 5'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fixed_to_float_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_to_float_seq
// Brief    : Multi-cycle signed fixed-point (binary point at FRAC_BITS) to
//            IEEE-754 single converter with start/done handshake.
//            Define ROUND_NEAREST_EN for round-to-nearest-even, else truncate.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_to_float_seq
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS = 31
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    localparam logic [FP_EXP_W-1:0] c_exp_offset = FP_EXP_W'(FP_BIAS - FRAC_BITS);

    f2f_state_t             r_state;
    logic                   r_sign;
    logic [31:0]            r_mag;
    logic [4:0]             r_pos;
    logic                   r_zero;
    logic [FP_EXP_W-1:0]    r_exp;
    logic [FP_MANT_W-1:0]   r_mant;
    logic [31:0]            r_result;
    logic                   r_done;
    logic                   r_busy;

    logic [31:0]            w_abs_in;
    logic [4:0]             w_pe_index;
    logic                   w_pe_valid;
    logic [31:0]            w_norm;
    logic [FP_EXP_W-1:0]    w_exp_final;
    logic [FP_MANT_W-1:0]   w_mant_final;
    logic                   w_unused_norm;

    // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
    assign w_abs_in = dataa[31] ? (~dataa + 32'd1) : dataa;

    priority_encoder32 u_lead_one (
        .i_data  (r_mag),
        .o_index (w_pe_index),
        .o_valid (w_pe_valid)
    );

    // Leading one moved to bit 31: [30:8] is the mantissa, [7] guard, [6:0] sticky.
    assign w_norm = r_mag << (5'd31 - r_pos);

`ifdef ROUND_NEAREST_EN
    logic                 r_guard;
    logic                 r_sticky;
    logic                 w_round_up;
    logic [FP_MANT_W:0]   w_mant_sum;

    assign w_round_up    = r_guard & (r_sticky | r_mant[0]);
    assign w_mant_sum    = {1'b0, r_mant} + {{FP_MANT_W{1'b0}}, w_round_up};
    assign w_mant_final  = w_mant_sum[FP_MANT_W] ? '0 : w_mant_sum[FP_MANT_W-1:0];
    assign w_exp_final   = r_exp + {{(FP_EXP_W-1){1'b0}}, w_mant_sum[FP_MANT_W]};
    assign w_unused_norm = w_norm[31];

    always_ff @(posedge clock) begin
        if (aclr) begin
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
        end else if (clk_en && r_state == F2F_NORM) begin
            r_guard  <= w_norm[7];
            r_sticky <= |w_norm[6:0];
        end
    end
`else
    assign w_mant_final  = r_mant;
    assign w_exp_final   = r_exp;
    assign w_unused_norm = ^{w_norm[31], w_norm[7:0]};
`endif

    always_ff @(posedge clock) begin
        if (aclr) begin
            r_state  <= F2F_IDLE;
            r_sign   <= 1'b0;
            r_mag    <= 32'd0;
            r_pos    <= 5'd0;
            r_zero   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                F2F_IDLE: begin
                    if (start) begin
                        r_sign  <= dataa[31];
                        r_mag   <= w_abs_in;
                        r_busy  <= 1'b1;
                        r_state <= F2F_ABS;
                    end
                end
                F2F_ABS: begin
                    r_pos   <= w_pe_index;
                    r_zero  <= ~w_pe_valid;
                    r_state <= F2F_NORM;
                end
                F2F_NORM: begin
                    r_exp   <= c_exp_offset + {3'b000, r_pos};
                    r_mant  <= w_norm[30:8];
                    r_state <= F2F_PACK;
                end
                F2F_PACK: begin
                    r_result <= r_zero ? 32'd0 : fp_pack(r_sign, w_exp_final, w_mant_final);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= F2F_DONE;
                end
                F2F_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sign  <= dataa[31];
                        r_mag   <= w_abs_in;
                        r_busy  <= 1'b1;
                        r_state <= F2F_ABS;
                    end else begin
                        r_state <= F2F_IDLE;
                    end
                end
                default: r_state <= F2F_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fixed_to_float_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_to_float_seq
// Brief    : Self-checking bench for fixed_to_float_seq against an arithmetic
//            reference model (honours ROUND_NEAREST_EN like the design).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float_seq;

    localparam int FRAC = 31;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    fixed_to_float_seq #(.FRAC_BITS(FRAC)) dut (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Value = signed(d) / 2^FRAC, normalised and rounded with integer arithmetic.
    function automatic logic [31:0] model_f2f(input logic [31:0] d);
        longint mag, q;
        int     p, e, sh;
        logic   s;
`ifdef ROUND_NEAREST_EN
        longint rem, half;
`endif
        if (d == 32'd0) return 32'd0;
        s   = d[31];
        mag = longint'({32'd0, d});
        if (s) mag = (longint'(1) << 32) - mag;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = 127 + p - FRAC;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh = p - 23;
            q  = mag >> sh;
`ifdef ROUND_NEAREST_EN
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
`endif
            if (q == (longint'(1) << 24)) begin
                q = longint'(1) << 23;
                e++;
            end
        end
        return {s, 8'(e), q[22:0]};
    endfunction

    // Drives one request and reports what the DUT produced; callers judge it.
    task automatic convert(input logic [31:0] d, output logic [31:0] res,
                           output int lat, output bit busy_ok);
        @(negedge clock);
        start = 1'b1;
        dataa = d;
        lat = 0;
        busy_ok = 1'b1;
        res = 32'hxxxxxxxx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            start = 1'b0;
            dataa = $urandom;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        aclr = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = 32'd0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (result !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %h want 00000000", result); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        aclr = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vin [6];
        logic [31:0] vexp[6];
        logic [31:0] res;
        int lat;
        bit bok;
        vin[0] = 32'h6EC1BCCD;
`ifdef ROUND_NEAREST_EN
        vexp[0] = 32'h3F5D837A;
        vexp[5] = 32'h3F800000;
`else
        vexp[0] = 32'h3F5D8379;
        vexp[5] = 32'h3F7FFFFF;
`endif
        vin[1] = 32'h40000000; vexp[1] = 32'h3F000000;
        vin[2] = 32'h80000000; vexp[2] = 32'hBF800000;
        vin[3] = 32'h00000001; vexp[3] = 32'h30000000;
        vin[4] = 32'h00000000; vexp[4] = 32'h00000000;
        vin[5] = 32'h7FFFFFFF;
        for (int i = 0; i < 6; i++) begin
            convert(vin[i], res, lat, bok);
            n_checks++;
            if (lat !== 4) begin n_errors++; $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat); end
            n_checks++;
            if (res !== vexp[i]) begin n_errors++; $display("FAIL directed_result[%h]: got %h want %h", vin[i], res, vexp[i]); end
            n_checks++;
            if (!bok) begin n_errors++; $display("FAIL directed_busy[%0d]: got bad busy profile want high n+1..n+3", i); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, res, want;
        int lat;
        bit bok;
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            d = $signed(d) >>> $urandom_range(0, 31);
            want = model_f2f(d);
            convert(d, res, lat, bok);
            n_checks++;
            if (res !== want || lat !== 4) begin
                n_errors++;
                $display("FAIL random[%h]: got %h lat %0d want %h lat 4", d, res, lat, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] da, db;
        logic [31:0] res[2];
        int cyc[2];
        int ndone;
        da = $urandom; db = $urandom;
        ndone = 0;
        cyc[0] = 0; cyc[1] = 0;
        res[0] = 32'd0; res[1] = 32'd0;
        @(negedge clock);
        start = 1'b1; dataa = da;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (ndone < 2) begin cyc[ndone] = c; res[ndone] = result; end
                ndone++;
            end
            if (c <= 3)       begin start = 1'b1; dataa = $urandom; end
            else if (c == 4)  begin start = 1'b1; dataa = db; end
            else              begin start = 1'b0; end
        end
        n_checks++;
        if (ndone !== 2) begin n_errors++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
        n_checks++;
        if (cyc[0] !== 4 || res[0] !== model_f2f(da)) begin
            n_errors++; $display("FAIL b2b_first: got %h at %0d want %h at 4", res[0], cyc[0], model_f2f(da));
        end
        n_checks++;
        if (cyc[1] !== 8 || res[1] !== model_f2f(db)) begin
            n_errors++; $display("FAIL b2b_second: got %h at %0d want %h at 8", res[1], cyc[1], model_f2f(db));
        end
    endtask

    task automatic test_clk_en();
        logic [31:0] da, prev, res;
        int first, nhigh;
        bit frozen_ok;
        da = $urandom | 32'h1;
        prev = result;
        first = 0; nhigh = 0; frozen_ok = 1'b1;
        res = 32'd0;
        @(negedge clock);
        start = 1'b1; dataa = da;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (done === 1'b1) begin
                nhigh++;
                if (first == 0) begin first = c; res = result; end
            end
            if (c >= 3 && c <= 5) begin
                if (busy !== 1'b1 || done !== 1'b0 || result !== prev) frozen_ok = 1'b0;
            end
            clk_en = ((c >= 2 && c <= 4) || (c >= 7 && c <= 8)) ? 1'b0 : 1'b1;
        end
        clk_en = 1'b1;
        n_checks++;
        if (first !== 7) begin n_errors++; $display("FAIL clken_latency: got %0d want 7", first); end
        n_checks++;
        if (res !== model_f2f(da)) begin n_errors++; $display("FAIL clken_result: got %h want %h", res, model_f2f(da)); end
        n_checks++;
        if (!frozen_ok) begin n_errors++; $display("FAIL clken_frozen: got outputs changing want held"); end
        n_checks++;
        if (nhigh !== 3) begin n_errors++; $display("FAIL clken_done_hold: got %0d done cycles want 3", nhigh); end
    endtask

    task automatic test_abort();
        logic [31:0] da, res;
        int lat, nspur;
        bit bok;
        da = $urandom | 32'h1;
        @(negedge clock);
        start = 1'b1; dataa = da;
        repeat (3) begin
            @(negedge clock);
            start = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_pack: got %b want 1", busy); end
        aclr = 1'b1;
        @(negedge clock);
        n_checks++;
        if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_clear: got result %h done %b busy %b want 0 0 0", result, done, busy);
        end
        aclr = 1'b0;
        nspur = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (done === 1'b1) nspur++;
        end
        n_checks++;
        if (nspur !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d pulses want 0", nspur); end
        da = $urandom;
        convert(da, res, lat, bok);
        n_checks++;
        if (res !== model_f2f(da) || lat !== 4) begin
            n_errors++; $display("FAIL abort_fresh: got %h lat %0d want %h lat 4", res, lat, model_f2f(da));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clk_en();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_to_float_seq.md
# fixed_to_float_seq

Multi-cycle converter from signed Q1.31 fixed point, the CORDIC datapath's native format, to IEEE-754 single precision. It is the return path of the accelerator: the CORDIC core produces a fixed-point cosine, and this block normalises, rounds and packs it into the float handed back on the custom-instruction `result` bus. It is a variable-latency custom-instruction slave with a `start`/`done` handshake.

## Interface
- `FRAC_BITS`, default 31: binary-point position of the input; legal range 1..31.
- `clock` in 1: single clock; all state changes on its rising edge.
- `aclr` in 1: reset, synchronous, active-high.
- `clk_en` in 1: global enable; when low, every register holds.
- `start` in 1: request; samples `dataa` when the request is accepted.
- `dataa` in 32: two's-complement fixed-point input, value = dataa / 2^FRAC_BITS.
- `result` out 32: IEEE-754 single; valid while `done` is high, held afterwards.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in states ABS, NORM and PACK.

## Operation
- FSM states: IDLE, ABS, NORM, PACK, DONE.
  - IDLE→ABS when `start` is high: latch the sign and the 32-bit magnitude. The magnitude of 0x80000000 is 2^31, carried unsigned.
  - ABS→NORM: find the leading-one position p (0..31), plus a zero flag.
  - NORM→PACK: unbiased exponent e = p − FRAC_BITS; biased exponent = 127 + e (8 bits).
    - p ≥ 23: mantissa = magnitude bits [p−1 : p−23]; remaining bits form guard and sticky.
    - p < 23: the magnitude is shifted left, so the result is exact and there are no guard bits.
  - PACK→DONE: round, then register `result` = {sign, exponent, mantissa[22:0]}.
    - A rounding carry out of the mantissa zeroes the mantissa and increments the exponent.
  - DONE→IDLE, or DONE→ABS if `start` is high in DONE (back-to-back accepted).
- `start` is ignored in ABS, NORM and PACK.
- Zero input, or zero magnitude: `result` = 0x00000000 (+0.0, sign forced to 0).
- Exponent never underflows or overflows for the legal FRAC_BITS range, so there are no denormal, infinity or NaN outputs.
- `clk_en` low freezes the FSM and all datapath registers; `done` stays at its current value.
- `aclr` high at any point: state becomes IDLE, `result` = 0, `done` = 0, `busy` = 0. The in-flight request is discarded with no done pulse.

## Timing
- Reset values: `result` = 0x00000000, `done` = 0, `busy` = 0, state IDLE.
- Latency: with `start` high in cycle n (IDLE, `clk_en` = 1), `done` is high in cycle n+4 only, with `result` valid that cycle.
- `busy` is high in cycles n+1..n+3.
- Throughput: one conversion per 4 cycles, when back-to-back starts are issued in DONE.
- Each cycle with `clk_en` = 0 adds one cycle to the latency.
- `result` is registered, with no combinational path from `dataa` to any output.

## Configuration
- `ROUND_NEAREST_EN` defined: round-to-nearest-even.
  - Increment when guard = 1 and (sticky = 1 or mantissa LSB = 1).
- Not defined: truncation; guard and sticky bits are discarded, and rounding/carry logic is not built.
- Latency is identical in both builds.

## Structure
- The shared package `cordic_pkg` holds:
  - FSM state enum `f2f_state_t`;
  - constants `FP_BIAS` = 127, `FP_MANT_W` = 23, `FP_EXP_W` = 8;
  - float field-packing helper.
- One sub-module: the existing `priority_encoder32`, reused for leading-one detection (`valid` = 0 means zero input).

## Test plan
- Reset then 0x6EC1BCCD (≈0.86529) → `done` in cycle n+4.
  - With `ROUND_NEAREST_EN`: `result` = 0x3F5D837A.
  - Without it: `result` = 0x3F5D8379.
- Boundary values:
  - 0x40000000 → 0x3F000000.
  - 0x80000000 → 0xBF800000.
  - 0x00000001 → 0x30000000.
  - 0x00000000 → 0x00000000.
- 0x7FFFFFFF → 0x3F800000 with rounding (carry into exponent); 0x3F7FFFFF without.
- `start` pulsed again in ABS/NORM → ignored.
  - A `start` issued in DONE → second result 4 cycles later.
  - Exactly one `done` per accepted start.
- `clk_en` dropped for 3 cycles during NORM → `done` at n+7; outputs frozen meanwhile.
- `aclr` asserted in PACK → next cycle `result` = 0, `done` = 0, `busy` = 0.
  - No done pulse for the aborted request.
  - A fresh start converts correctly.
